// File: rtl/bp_fe_pkg.sv
// Front-end shared types: processor configs, FE queue entry layout and default queue depth.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0
    } bp_params_e;

    localparam int unsigned vaddr_width_gp               = 39;
    localparam int unsigned instr_width_gp               = 32;
    localparam int unsigned branch_metadata_fwd_width_gp = 36;
    localparam int unsigned fe_queue_els_gp              = 8;

    typedef enum logic [0:0] {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_queue_type_e;

    typedef struct packed {
        bp_fe_queue_type_e                        msg_type;
        logic [vaddr_width_gp-1:0]                pc;
        logic [instr_width_gp-1:0]                instr;
        logic [branch_metadata_fwd_width_gp-1:0]  branch_metadata_fwd;
    } bp_fe_queue_s;

    // Entry width for a given processor configuration.
    function automatic int unsigned fe_queue_width(input bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_queue_s);
            default:          return $bits(bp_fe_queue_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_fe_queue_buffer_if.sv
// FE-to-BE queue handshake bundle: enqueue side, read side and commit/replay controls.
interface bp_fe_queue_buffer_if
    import bp_fe_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
);
    localparam int unsigned fe_queue_width_lp = fe_queue_width(bp_params_p);

    logic [fe_queue_width_lp-1:0] fe_queue_i;
    logic                         fe_queue_v_i;
    logic                         fe_queue_ready_and_o;
    logic [fe_queue_width_lp-1:0] fe_queue_o;
    logic                         fe_queue_v_o;
    logic                         fe_queue_yumi_i;
    logic                         clr_v_i;
    logic                         roll_v_i;
    logic                         deq_v_i;
    logic                         empty_o;

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, clr_v_i, roll_v_i, deq_v_i,
        input  fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o, empty_o
    );

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, clr_v_i, roll_v_i, deq_v_i,
        output fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o, empty_o
    );
endinterface

// File: rtl/bp_fe_queue_ptr.sv
// Wrap-bit queue pointer: clear beats load beats increment.
module bp_fe_queue_ptr #(
    parameter int unsigned ptr_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clr_i,
    input  logic                   ld_i,
    input  logic [ptr_width_p-1:0] ld_val_i,
    input  logic                   inc_i,
    output logic [ptr_width_p-1:0] ptr_o
);
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            ptr_o <= '0;
        end else if (ld_i) begin
            ptr_o <= ld_val_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + ptr_width_p'(1);
        end
    end
endmodule

// File: rtl/bp_fe_queue_buffer.sv
// FE queue with separate read and commit pointers so the BE can replay uncommitted entries.
// Optional same-cycle bypass of an enqueue into an empty read window: BP_FE_QUEUE_BYPASS_EN.
module bp_fe_queue_buffer
    import bp_fe_pkg::*;
#(
    parameter bp_params_e  bp_params_p = e_bp_default_cfg,
    parameter int unsigned els_p       = fe_queue_els_gp
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_fe_queue_buffer_if.slave  fe_if
);
    localparam int unsigned fe_queue_width_lp = fe_queue_width(bp_params_p);
    localparam int unsigned lg_els_lp         = $clog2(els_p);
    localparam int unsigned ptr_width_lp      = lg_els_lp + 1;

    logic [ptr_width_lp-1:0]      wptr, rptr, cptr, rptr_ld_val;
    logic [fe_queue_width_lp-1:0] mem [els_p];
    logic                         full, ready, enq, clr, roll, yumi_inc;

    // Full when write pointer is exactly one lap ahead of the commit pointer.
    assign full        = ((wptr ^ cptr) == {1'b1, {lg_els_lp{1'b0}}});
    assign clr         = fe_if.clr_v_i;
    assign ready       = ~reset_i & ~full & ~clr;
    assign enq         = fe_if.fe_queue_v_i & ready;
    assign roll        = fe_if.roll_v_i & ~clr;
    assign yumi_inc    = fe_if.fe_queue_yumi_i & ~roll;
    assign rptr_ld_val = cptr + ptr_width_lp'(fe_if.deq_v_i);

    bp_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) wptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr),
        .ld_i(1'b0), .ld_val_i('0), .inc_i(enq), .ptr_o(wptr)
    );

    bp_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) rptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr),
        .ld_i(roll), .ld_val_i(rptr_ld_val), .inc_i(yumi_inc), .ptr_o(rptr)
    );

    bp_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) cptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr),
        .ld_i(1'b0), .ld_val_i('0), .inc_i(fe_if.deq_v_i), .ptr_o(cptr)
    );

    // Storage is never reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr[lg_els_lp-1:0]] <= fe_if.fe_queue_i;
        end
    end

    assign fe_if.fe_queue_ready_and_o = ready;
    assign fe_if.empty_o              = reset_i | (cptr == wptr);

`ifdef BP_FE_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass             = (rptr == wptr);
    assign fe_if.fe_queue_v_o = ~reset_i & (~bypass | enq);
    assign fe_if.fe_queue_o   = bypass ? fe_if.fe_queue_i : mem[rptr[lg_els_lp-1:0]];
`else
    assign fe_if.fe_queue_v_o = ~reset_i & (rptr != wptr);
    assign fe_if.fe_queue_o   = mem[rptr[lg_els_lp-1:0]];
`endif

    deq_has_read_entry_a: assert property (
        @(posedge clk_i) disable iff (reset_i || clr)
        fe_if.deq_v_i |-> (cptr != rptr)
    ) else $error("deq_v_i with no read entry to commit");

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer; expectations follow BP_FE_QUEUE_BYPASS_EN when defined.
module tb_bp_fe_queue_buffer;
    import bp_fe_pkg::*;

    localparam int unsigned els_lp = 8;
`ifdef BP_FE_QUEUE_BYPASS_EN
    localparam bit bypass_lp = 1'b1;
`else
    localparam bit bypass_lp = 1'b0;
`endif

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bp_fe_queue_buffer_if #(.bp_params_p(e_bp_default_cfg)) fe_if ();

    bp_fe_queue_buffer #(
        .bp_params_p(e_bp_default_cfg),
        .els_p      (els_lp)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .fe_if  (fe_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bp_fe_queue_s mk(input logic [38:0] pc);
        bp_fe_queue_s e;
        e                     = '0;
        e.msg_type            = e_fe_fetch;
        e.pc                  = pc;
        e.instr               = pc[31:0] ^ 32'h0000_0013;
        e.branch_metadata_fwd = 36'(pc);
        return e;
    endfunction

    function automatic logic [63:0] out_pc();
        bp_fe_queue_s e;
        e = fe_if.fe_queue_o;
        return 64'(e.pc);
    endfunction

    task automatic idle();
        fe_if.fe_queue_i      = '0;
        fe_if.fe_queue_v_i    = 1'b0;
        fe_if.fe_queue_yumi_i = 1'b0;
        fe_if.clr_v_i         = 1'b0;
        fe_if.roll_v_i        = 1'b0;
        fe_if.deq_v_i         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enq(input logic [38:0] pc);
        fe_if.fe_queue_v_i = 1'b1;
        fe_if.fe_queue_i   = mk(pc);
        #1;
        check_eq("enq_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd1);
        tick();
        idle();
    endtask

    task automatic yumi_expect(input string tag, input logic [63:0] pc);
        #1;
        check_eq(tag, out_pc(), pc);
        fe_if.fe_queue_yumi_i = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        // Reset behaviour
        tick();
        check_eq("rst_v_o", 64'(fe_if.fe_queue_v_o), 64'd0);
        check_eq("rst_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd0);
        check_eq("rst_empty", 64'(fe_if.empty_o), 64'd1);
        tick();
        reset_i = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd1);
        check_eq("post_rst_v_o", 64'(fe_if.fe_queue_v_o), 64'd0);

        // Fill to full without reads
        for (int i = 0; i < 8; i++) enq(39'h80000000 + 39'(4 * i));
        #1;
        check_eq("full_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd0);
        check_eq("full_empty", 64'(fe_if.empty_o), 64'd0);
        check_eq("full_v_o", 64'(fe_if.fe_queue_v_o), 64'd1);
        check_eq("full_head_pc", out_pc(), 64'h80000000);
        check_eq("full_wptr_wrap", 64'(dut.wptr), 64'h8);

        // Read three, commit two, replay from the commit point
        yumi_expect("yumi0", 64'h80000000);
        yumi_expect("yumi1", 64'h80000004);
        yumi_expect("yumi2", 64'h80000008);
        fe_if.deq_v_i = 1'b1; tick(); tick(); idle();
        fe_if.roll_v_i = 1'b1; tick(); idle();
        #1;
        check_eq("roll_pc", out_pc(), 64'h80000008);
        yumi_expect("replay0", 64'h80000008);
        yumi_expect("replay1", 64'h8000000C);
        check_eq("after_replay_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd1);

        // Roll + deq + yumi in one cycle with cptr=2
        check_eq("pre_rdy_cptr", 64'(dut.cptr), 64'd2);
        fe_if.roll_v_i = 1'b1; fe_if.deq_v_i = 1'b1; fe_if.fe_queue_yumi_i = 1'b1;
        tick(); idle();
        #1;
        check_eq("rdy_cptr", 64'(dut.cptr), 64'd3);
        check_eq("rdy_rptr", 64'(dut.rptr), 64'd3);
        check_eq("rdy_pc", out_pc(), 64'h8000000C);

        // Refill to full, then deq and enqueue in the same cycle
        yumi_expect("yumi3", 64'h8000000C);
        yumi_expect("yumi4", 64'h80000010);
        enq(39'h80000020); enq(39'h80000024); enq(39'h80000028);
        #1;
        check_eq("refull_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd0);
        fe_if.deq_v_i = 1'b1; fe_if.fe_queue_v_i = 1'b1; fe_if.fe_queue_i = mk(39'h8000002C);
        #1;
        check_eq("deq_no_bypass_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd0);
        tick(); idle();
        check_eq("deq_wptr_hold", 64'(dut.wptr), 64'd11);
        enq(39'h8000002C);
        check_eq("wptr_after_enq", 64'(dut.wptr), 64'd12);
        yumi_expect("wrap_rd0", 64'h80000014);
        yumi_expect("wrap_rd1", 64'h80000018);
        yumi_expect("wrap_rd2", 64'h8000001C);
        yumi_expect("wrap_rd3", 64'h80000020);

        // Flush, then flush again with a live enqueue on a 5-entry queue
        fe_if.clr_v_i = 1'b1; tick(); idle();
        #1;
        check_eq("clr_empty", 64'(fe_if.empty_o), 64'd1);
        for (int i = 0; i < 5; i++) enq(39'h90000000 + 39'(4 * i));
        fe_if.clr_v_i = 1'b1; fe_if.fe_queue_v_i = 1'b1; fe_if.fe_queue_i = mk(39'h0DEAD000);
        #1;
        check_eq("clr_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd0);
        tick(); idle();
        #1;
        check_eq("clr5_v_o", 64'(fe_if.fe_queue_v_o), 64'd0);
        check_eq("clr5_empty", 64'(fe_if.empty_o), 64'd1);
        enq(39'h0A000000);
        check_eq("post_clr_pc", out_pc(), 64'h0A000000);
        yumi_expect("post_clr_yumi", 64'h0A000000);
        check_eq("post_clr_drained_v_o", 64'(fe_if.fe_queue_v_o), 64'd0);
        check_eq("uncommitted_empty", 64'(fe_if.empty_o), 64'd0);
        fe_if.deq_v_i = 1'b1; tick(); idle();
        #1;
        check_eq("committed_empty", 64'(fe_if.empty_o), 64'd1);

        // Enqueue-to-valid latency, then simultaneous enqueue and yumi
        fe_if.fe_queue_v_i = 1'b1; fe_if.fe_queue_i = mk(39'h1000);
        #1;
        check_eq("lat_same_cycle_v_o", 64'(fe_if.fe_queue_v_o), 64'(bypass_lp));
        if (bypass_lp) check_eq("lat_bypass_pc", out_pc(), 64'h1000);
        tick(); idle();
        #1;
        check_eq("lat_next_v_o", 64'(fe_if.fe_queue_v_o), 64'd1);
        fe_if.fe_queue_v_i = 1'b1; fe_if.fe_queue_i = mk(39'h2000);
        yumi_expect("enq_yumi_pc", 64'h1000);
        #1;
        check_eq("enq_yumi_next_pc", out_pc(), 64'h2000);
        check_eq("enq_yumi_next_v_o", 64'(fe_if.fe_queue_v_o), 64'd1);

        // Reset mid-operation discards everything
        reset_i = 1'b1;
        #1;
        check_eq("midrst_v_o", 64'(fe_if.fe_queue_v_o), 64'd0);
        check_eq("midrst_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd0);
        tick();
        reset_i = 1'b0;
        #1;
        check_eq("midrst_after_ready", 64'(fe_if.fe_queue_ready_and_o), 64'd1);
        check_eq("midrst_after_v_o", 64'(fe_if.fe_queue_v_o), 64'd0);
        check_eq("midrst_after_empty", 64'(fe_if.empty_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_fe_queue_buffer.md
BP_FE_QUEUE_BUFFER -- requirements
Module: bp_fe_queue_buffer

Interface
REQ-001 SHALL have parameter: bp_params_p, e_bp_default_cfg, processor configuration (supplies vaddr/branch-metadata widths, hence fe_queue_width_lp).
REQ-002 SHALL have parameter: els_p, 8, entry count; power of 2, at least 2.
REQ-003 SHALL have port: clk_i  input  1  sole clock; the block uses one clock.
REQ-004 SHALL have port: reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: fe_queue_i  input  fe_queue_width_lp  bp_fe_queue_s entry from the FE controller.
REQ-006 SHALL have port: fe_queue_v_i  input  1  enqueue valid.
REQ-007 SHALL have port: fe_queue_ready_and_o  output  1  enqueue ready (valid/ready-and handshake).
REQ-008 SHALL have port: fe_queue_o  output  fe_queue_width_lp  entry at the read pointer.
REQ-009 SHALL have port: fe_queue_v_o  output  1  read entry valid.
REQ-010 SHALL have port: fe_queue_yumi_i  input  1  BE takes the read entry; legal only when fe_queue_v_o=1.
REQ-011 SHALL have port: clr_v_i  input  1  flush all entries (redirect).
REQ-012 SHALL have port: roll_v_i  input  1  rewind the read pointer to the commit pointer (replay).
REQ-013 SHALL have port: deq_v_i  input  1  commit (release) the oldest read entry.
REQ-014 SHALL have port: empty_o  output  1  no uncommitted entries (cptr==wptr).

Function
REQ-015 SHALL keep three pointers (wptr, rptr, cptr), each $clog2(els_p)+1 bits, with the MSB used as a wrap bit; the low bits index storage and wrap modulo els_p.
REQ-016 SHALL assert full when wptr and cptr differ only in the MSB, and drive fe_queue_ready_and_o = ~full & ~clr_v_i.
REQ-017 SHALL write fe_queue_i to mem[wptr] and increment wptr on the cycle fe_queue_v_i & fe_queue_ready_and_o holds.
REQ-018 SHALL drive fe_queue_v_o = (rptr != wptr) and fe_queue_o = mem[rptr] combinationally.
REQ-019 SHALL increment rptr on a yumi, and increment cptr on deq_v_i; deq_v_i when cptr==rptr is illegal and is flagged by an assertion.
REQ-020 SHALL apply priority clr > roll > normal operation.
REQ-021 SHALL, on clr_v_i, set all pointers to 0 on the next edge, and drop any same-cycle enqueue, yumi or deq.
REQ-022 SHALL, on roll_v_i, set rptr to cptr (or to cptr+1 if deq_v_i is also asserted), ignore a same-cycle yumi, and still accept a same-cycle enqueue.
REQ-023 SHALL allow a simultaneous enqueue and yumi in any non-full state, with both pointers advancing independently.
REQ-024 SHALL make a freed slot enqueueable on the cycle after the deq_v_i that freed it (no same-cycle full bypass).
REQ-025 SHALL give enqueue-to-fe_queue_v_o latency of 1 cycle (0 cycles with REQ-029).

Reset
REQ-026 SHALL, while reset_i is high, zero wptr/rptr/cptr and drive fe_queue_v_o=0, fe_queue_ready_and_o=0, empty_o=1.
REQ-027 SHALL NOT reset storage contents; fe_queue_o is don't-care while fe_queue_v_o=0.
REQ-028 SHALL let reset asserted mid-operation discard all entries, and raise ready on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, when BP_FE_QUEUE_BYPASS_EN is defined and rptr==wptr, drive fe_queue_v_o=fe_queue_v_i & fe_queue_ready_and_o and fe_queue_o=fe_queue_i in the same cycle; the entry is still written to mem[wptr], so roll can replay it, and a bypassed yumi advances rptr together with wptr.
REQ-030 SHALL, without BP_FE_QUEUE_BYPASS_EN, never drive fe_queue_o from fe_queue_i.

Structure
REQ-031 SHALL take bp_fe_queue_s and its width from the existing core-interface macros, and SHALL place the default depth constant (fe_queue_els_gp = 8) in bp_fe_pkg.
REQ-032 SHALL implement each pointer as an instance of one sub-module, bp_fe_queue_ptr (wrap-bit counter with increment and load); storage SHALL be a 1R1W register array.

Verification
REQ-033 SHALL be verified by this scenario: enqueue 8 entries (pc 0x80000000+4i) with no yumi -> ready=0 after the 8th; empty_o=0; fe_queue_o pc=0x80000000.
REQ-034 SHALL be verified by this scenario: yumi 3 entries, deq 2, then roll -> fe_queue_o pc=0x80000008, and next yumi order is 0x80000008, 0x8000000C.
REQ-035 SHALL be verified by this scenario: clr_v_i with fe_queue_v_i=1 on a 5-entry queue -> next cycle fe_queue_v_o=0, empty_o=1, the dropped entry is never seen.
REQ-036 SHALL be verified by this scenario: full queue, deq_v_i and fe_queue_v_i in the same cycle -> no enqueue that cycle; enqueue accepted the next cycle; ptr wrap bit toggles.
REQ-037 SHALL be verified by this scenario: roll_v_i + deq_v_i + yumi in the same cycle with cptr=2 -> cptr=3, rptr=3, yumi ignored.
REQ-038 SHALL be verified by this scenario: empty queue, enqueue pc 0x1000 -> fe_queue_v_o=1 in the same cycle with BP_FE_QUEUE_BYPASS_EN, and the next cycle without it.
